acl_spi_slot: RTL and testbench

//  MMIO-bus SPI master slot. It sits on the bus between the fpro bridge output and
//  the board SPI pins (acl_sclk/acl_mosi/acl_miso/acl_ss_n) and drives the accelerometer.

---
 rtl/acl_spi_slot.sv | 143 ++++++++++++++
 tb/tb_acl_spi_slot.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acl_spi_slot.sv
// MMIO SPI master slot: software sets divider/mode/slave select, writes a byte,
// and the slot shifts it out MSB-first while capturing eight bits from MISO.
module acl_spi_slot #(
  parameter int          S        = 1,
  parameter logic [15:0] DVSR_RST = 16'd49
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  output logic         spi_sclk,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic [S-1:0] spi_ss_n
);

  typedef enum logic [1:0] {IDLE, CPHA_DLY, P0, P1} state_t;

  state_t       state;
  logic [15:0]  dvsr;
  logic [15:0]  half_cnt;
  logic         cpol;
  logic         cpha;
  logic [7:0]   tx_sh;
  logic [7:0]   rx_sh;
  logic [7:0]   rx_byte;
  logic [2:0]   bit_cnt;
  logic [S-1:0] ss_n;
  logic         sclk;
  logic         wr_en;
  logic         half_done;
  logic         ready;

  assign wr_en     = cs & write;
  assign half_done = (half_cnt == dvsr);
  assign ready     = (state == IDLE);

  // Reads carry no side effects, so the strobe and the upper data bits go unused.
  logic unused_bits;
  assign unused_bits = ^{read, wr_data[31:18]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dvsr <= DVSR_RST;
      cpol <= 1'b0;
      cpha <= 1'b0;
      ss_n <= '1;
    end else begin
      if (wr_en && addr == 5'd1)
        ss_n <= wr_data[S-1:0];
      if (wr_en && addr == 5'd3 && ready) begin
        dvsr <= wr_data[15:0];
        cpol <= wr_data[16];
        cpha <= wr_data[17];
      end
    end
  end

  // sclk is loaded together with the state it belongs to, so it is a clean flop output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      half_cnt <= 16'd0;
      bit_cnt  <= 3'd0;
      tx_sh    <= 8'd0;
      rx_sh    <= 8'd0;
      rx_byte  <= 8'd0;
      sclk     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en && addr == 5'd2) begin
            tx_sh    <= wr_data[7:0];
            bit_cnt  <= 3'd0;
            half_cnt <= 16'd0;
            sclk     <= cpol;
            state    <= cpha ? CPHA_DLY : P0;
          end else if (wr_en && addr == 5'd3) begin
            sclk <= wr_data[16];
          end else begin
            sclk <= cpol;
          end
        end
        CPHA_DLY: begin
          if (half_done) begin
            half_cnt <= 16'd0;
            sclk     <= ~cpol;
            state    <= P0;
          end else begin
            half_cnt <= half_cnt + 16'd1;
          end
        end
        P0: begin
          if (half_done) begin
            half_cnt <= 16'd0;
            rx_sh    <= {rx_sh[6:0], spi_miso};
            sclk     <= cpol ^ ~cpha;
            state    <= P1;
          end else begin
            half_cnt <= half_cnt + 16'd1;
          end
        end
        P1: begin
          if (half_done) begin
            half_cnt <= 16'd0;
            if (bit_cnt == 3'd7) begin
              rx_byte <= rx_sh;
              sclk    <= cpol;
              state   <= IDLE;
            end else begin
              tx_sh   <= {tx_sh[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              sclk    <= cpol ^ cpha;
              state   <= P0;
            end
          end else begin
            half_cnt <= half_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (addr)
      5'd0:    rd_data = {23'd0, ready, rx_byte};
      5'd1:    rd_data[S-1:0] = ss_n;
      5'd3:    rd_data = {14'd0, cpha, cpol, dvsr};
      default: rd_data = 32'd0;
    endcase
  end

  assign spi_sclk = sclk;
  assign spi_mosi = tx_sh[7];
  assign spi_ss_n = ss_n;

endmodule

// File: tb/tb_acl_spi_slot.sv
// Bench for acl_spi_slot: a transfer-level model (phase arithmetic over elapsed
// cycles) checked every cycle, plus directed cases with hand-derived results.
module tb_acl_spi_slot;
  localparam int S = 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         cs = 1'b0;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [4:0]   addr = 5'd0;
  logic [31:0]  wr_data = 32'd0;
  wire  [31:0]  rd_data;
  wire          spi_sclk;
  wire          spi_mosi;
  wire  [S-1:0] spi_ss_n;
  logic         loop_en = 1'b0;
  logic         miso_drv = 1'b0;
  wire          spi_miso = loop_en ? spi_mosi : miso_drv;

  acl_spi_slot #(.S(S)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_ss_n(spi_ss_n)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  logic check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer model: a transfer is a number of equal half-periods; everything
  // the pins show is derived from how many cycles have elapsed since the start.
  logic         m_busy;
  int           m_k;
  logic [7:0]   m_tx, m_rx, m_acc;
  logic [15:0]  m_dvsr;
  logic         m_cpol, m_cpha, m_mosi_idle;
  logic [S-1:0] m_ss;

  always @(posedge clk or negedge reset_n) begin : model
    int h, p, nph;
    if (!reset_n) begin
      m_busy = 1'b0; m_k = 0; m_tx = 8'd0; m_rx = 8'd0; m_acc = 8'd0;
      m_dvsr = 16'd49; m_cpol = 1'b0; m_cpha = 1'b0; m_mosi_idle = 1'b0; m_ss = '1;
    end else begin
      h   = int'(m_dvsr) + 1;
      nph = m_cpha ? 17 : 16;
      if (m_busy) begin
        p = m_k / h;
        if (m_k % h == h - 1 && (m_cpha ? (p >= 1 && (p - 1) % 2 == 0) : (p % 2 == 0)))
          m_acc = {m_acc[6:0], spi_miso};
        m_k++;
        if (m_k == nph * h) begin
          m_busy = 1'b0;
          m_rx = m_acc;
          m_mosi_idle = m_tx[0];
        end
      end else if (cs && write && addr == 5'd2) begin
        m_busy = 1'b1; m_k = 0; m_tx = wr_data[7:0];
      end else if (cs && write && addr == 5'd3) begin
        m_dvsr = wr_data[15:0]; m_cpol = wr_data[16]; m_cpha = wr_data[17];
      end
      if (cs && write && addr == 5'd1) m_ss = wr_data[S-1:0];
    end
  end

  always @(negedge clk) begin : compare
    int h, p, q, b;
    logic e_sclk, e_mosi;
    logic [31:0] e_rd;
    if (check_en) begin
      h = int'(m_dvsr) + 1;
      e_sclk = m_cpol;
      e_mosi = m_mosi_idle;
      if (m_busy) begin
        p = m_k / h;
        e_mosi = m_tx[7];
        if (!(m_cpha && p == 0)) begin
          q = m_cpha ? p - 1 : p;
          b = q / 2;
          e_mosi = m_tx[7 - b];
          e_sclk = m_cpol ^ (m_cpha ? (q % 2 == 0) : (q % 2 == 1));
        end
      end
      case (addr)
        5'd0:    e_rd = {23'd0, !m_busy, m_rx};
        5'd1:    e_rd = {{(32-S){1'b0}}, m_ss};
        5'd3:    e_rd = {14'd0, m_cpha, m_cpol, m_dvsr};
        default: e_rd = 32'd0;
      endcase
      chk("sclk", {31'd0, spi_sclk}, {31'd0, e_sclk});
      chk("mosi", {31'd0, spi_mosi}, {31'd0, e_mosi});
      chk("ss_n", {{(32-S){1'b0}}, spi_ss_n}, {{(32-S){1'b0}}, m_ss});
      chk("rd_data", rd_data, e_rd);
    end
  end

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk); #1;
    cs = 1'b0; write = 1'b0; addr = 5'd0; wr_data = 32'd0;
  endtask

  logic mosi_hist [0:4095];

  // Called one cycle after the write cycle; returns the cycle index (write cycle = 0)
  // at which ready reads back as 1, plus the number of SCLK rising edges seen.
  task automatic wait_ready(input int start, output int cyc, output int rises);
    logic prev;
    cyc = start;
    rises = 0;
    prev = spi_sclk;
    mosi_hist[cyc] = spi_mosi;
    while (rd_data[8] !== 1'b1 && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      mosi_hist[cyc] = spi_mosi;
      if (spi_sclk && !prev) rises++;
      prev = spi_sclk;
    end
    if (cyc >= 4000) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc, rises, busy_cnt;
    logic [7:0] bits;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check_en = 1'b1;
    #1;
    chk("rst_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    chk("rst_ss_n", {31'd0, spi_ss_n}, 32'd1);
    chk("rst_status", rd_data, 32'h0000_0100);
    addr = 5'd3; #1;
    chk("rst_ctrl", rd_data, 32'h0000_0031);
    addr = 5'd0;

    // mode 0, dvsr=1, loopback
    bus_wr(5'd3, 32'h0000_0001);
    loop_en = 1'b1;
    bus_wr(5'd2, 32'h0000_00A5);
    wait_ready(1, cyc, rises);
    chk("t1_latency", cyc, 33);
    chk("t1_rises", rises, 8);
    chk("t1_rx", rd_data, 32'h0000_01A5);

    // mode 3, dvsr=0, miso held high
    loop_en = 1'b0; miso_drv = 1'b1;
    bus_wr(5'd3, 32'h0003_0000);
    chk("t2_idle_sclk", {31'd0, spi_sclk}, 32'd1);
    bus_wr(5'd2, 32'h0000_003C);
    wait_ready(1, cyc, rises);
    for (int i = 0; i < 8; i++) bits[7 - i] = mosi_hist[2 + 2 * i];
    chk("t2_latency", cyc, 18);
    chk("t2_mosi_bits", {24'd0, bits}, 32'h0000_003C);
    chk("t2_rx", rd_data, 32'h0000_01FF);

    // data write during a transfer is dropped
    bus_wr(5'd3, 32'h0000_0001);
    loop_en = 1'b1;
    bus_wr(5'd2, 32'h0000_00A5);
    repeat (5) @(posedge clk);
    bus_wr(5'd2, 32'h0000_0011);
    wait_ready(1, cyc, rises);
    chk("t3_rx", rd_data, 32'h0000_01A5);
    busy_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rd_data[8] !== 1'b1) busy_cnt++;
    end
    chk("t3_single_xfer", busy_cnt, 0);

    // ctrl write while busy is dropped
    bus_wr(5'd2, 32'h0000_005A);
    bus_wr(5'd3, 32'h0000_0007);
    addr = 5'd3; #1;
    chk("t4_ctrl_busy", rd_data, 32'h0000_0001);
    addr = 5'd0;
    wait_ready(1, cyc, rises);
    bus_wr(5'd3, 32'h0000_0007);
    addr = 5'd3; #1;
    chk("t4_ctrl_idle", rd_data, 32'h0000_0007);
    addr = 5'd0;

    // slave select is plain software state
    bus_wr(5'd1, 32'h0000_0000);
    chk("t5_ss_low", {31'd0, spi_ss_n}, 32'd0);
    addr = 5'd1; #1;
    chk("t5_rd_low", rd_data, 32'd0);
    addr = 5'd0;
    bus_wr(5'd1, 32'h0000_0001);
    chk("t5_ss_high", {31'd0, spi_ss_n}, 32'd1);
    addr = 5'd1; #1;
    chk("t5_rd_high", rd_data, 32'd1);
    addr = 5'd0;

    // asynchronous reset in the middle of a transfer
    bus_wr(5'd3, 32'h0000_0001);
    bus_wr(5'd1, 32'h0000_0000);
    bus_wr(5'd2, 32'h0000_00FF);
    repeat (17) @(posedge clk);
    #1 chk("t6_pre_mosi", {31'd0, spi_mosi}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("t6_mosi", {31'd0, spi_mosi}, 32'd0);
    chk("t6_ss_n", {31'd0, spi_ss_n}, 32'd1);
    chk("t6_status", rd_data, 32'h0000_0100);
    @(posedge clk); #1 reset_n = 1'b1;

    // randomized traffic, every cycle checked against the model
    loop_en = 1'b0;
    bus_wr(5'd3, 32'h0000_0000);
    for (int n = 0; n < 6000; n++) begin
      @(posedge clk); #1;
      miso_drv = 1'($urandom);
      read = 1'($urandom);
      cs = ($urandom_range(0, 3) != 0);
      write = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2: addr = 5'd2;
        3, 4:    addr = 5'd3;
        5:       addr = 5'd1;
        6, 7:    addr = 5'd0;
        default: addr = 5'($urandom_range(4, 31));
      endcase
      wr_data = $urandom;
      if (addr == 5'd3) wr_data = wr_data & 32'h0003_0003;
    end
    @(posedge clk); #1;
    cs = 1'b0; write = 1'b0; read = 1'b0;
    repeat (200) @(posedge clk);
    check_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
